// File: rtl/cpu7_csr_exc_pkg.sv
// Shared CSR addresses, field positions and register layouts for the cpu7 CSR
// file with exception sequencing and timer.
package cpu7_csr_exc_pkg;

  localparam int CSR_CRMD   = 'h00;
  localparam int CSR_PRMD   = 'h01;
  localparam int CSR_ECFG   = 'h04;
  localparam int CSR_ESTAT  = 'h05;
  localparam int CSR_ERA    = 'h06;
  localparam int CSR_EENTRY = 'h0C;
  localparam int CSR_SAVE0  = 'h30;
  localparam int CSR_TID    = 'h40;
  localparam int CSR_TCFG   = 'h41;
  localparam int CSR_TVAL   = 'h42;
  localparam int CSR_TICLR  = 'h44;

  // LIE bits 10 and 12 are reserved and always read zero.
  localparam logic [12:0] ECFG_LIE_MASK = 13'h0BFF;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  // Shared layout of CRMD {IE, PLV} and PRMD {PIE, PPLV}.
  typedef struct packed {
    logic       ie;
    logic [1:0] plv;
  } mode_t;

endpackage

// File: rtl/cpu7_csr_timer.sv
// Countdown timer holding TCFG and TVAL; emits a one-cycle expiry pulse
// whenever an enabled count sits at zero.
module cpu7_csr_timer
  import cpu7_csr_exc_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_tcfg_we,
  input  logic [TIMER_W-1:0] i_tcfg_wdata,
  output logic [TIMER_W-1:0] o_tcfg,
  output logic [TIMER_W-1:0] o_tval,
  output logic               o_expire
);

  logic               r_en;
  logic               r_periodic;
  logic [TIMER_W-3:0] r_initval;
  logic [TIMER_W-1:0] r_tval;

  assign o_expire = r_en && (r_tval == '0);
  assign o_tcfg   = {r_initval, r_periodic, r_en};
  assign o_tval   = r_tval;

  // A config write overrides any reload/decrement in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_initval  <= '0;
      r_tval     <= '0;
    end else if (i_tcfg_we) begin
      r_en       <= i_tcfg_wdata[TCFG_EN];
      r_periodic <= i_tcfg_wdata[TCFG_PERIODIC];
      r_initval  <= i_tcfg_wdata[TIMER_W-1:2];
      if (i_tcfg_wdata[TCFG_EN]) r_tval <= TIMER_W'(i_tcfg_wdata[TIMER_W-1:2]);
    end else if (o_expire) begin
      if (r_periodic) r_tval <= TIMER_W'(r_initval);
      else            r_en   <= 1'b0;
    end else if (r_en) begin
      r_tval <= r_tval - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/cpu7_csr_exc.sv
// cpu7 CSR file: combinational read port, registered write port, exception
// entry / ERTN sequencing, interrupt status and a countdown timer.
module cpu7_csr_exc
  import cpu7_csr_exc_pkg::*;
#(
  parameter int GRLEN    = 32,
  parameter int CSR_BIT  = 14,
  parameter int NUM_SAVE = 4,
  parameter int TIMER_W  = 32,
  parameter int HWI_NUM  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CSR_BIT-1:0] csr_raddr,
  output logic [GRLEN-1:0]   csr_rdata,
  input  logic [CSR_BIT-1:0] csr_waddr,
  input  logic [GRLEN-1:0]   csr_wdata,
  input  logic               csr_wen,
  input  logic               excp_valid,
  input  logic [5:0]         excp_ecode,
  input  logic [8:0]         excp_esubcode,
  input  logic [GRLEN-1:0]   excp_pc,
  input  logic               ertn_valid,
  input  logic [HWI_NUM-1:0] hw_int,
  output logic [GRLEN-1:0]   csr_eentry,
  output logic [GRLEN-1:0]   csr_era,
  output logic [1:0]         csr_plv,
  output logic               int_pending
);

  mode_t              r_crmd;
  mode_t              r_prmd;
  logic [12:0]        r_lie;
  logic [1:0]         r_is_sw;
  logic [HWI_NUM-1:0] r_hwi;
  logic               r_ti;
  logic [5:0]         r_ecode;
  logic [8:0]         r_esub;
  logic [GRLEN-1:0]   r_era;
  logic [GRLEN-7:0]   r_eentry;
  logic [GRLEN-1:0]   r_save [NUM_SAVE];
  logic [GRLEN-1:0]   r_tid;
  logic               r_int;

  logic [12:0]        w_is;
  logic [31:0]        w_estat;
  logic [TIMER_W-1:0] w_tcfg;
  logic [TIMER_W-1:0] w_tval;
  logic               w_expire;
  logic               w_we_crmd, w_we_prmd, w_we_ecfg, w_we_estat;
  logic               w_we_era, w_we_eentry, w_we_tid, w_we_tcfg, w_we_ticlr;

  assign w_we_crmd   = csr_wen && (csr_waddr == CSR_BIT'(CSR_CRMD));
  assign w_we_prmd   = csr_wen && (csr_waddr == CSR_BIT'(CSR_PRMD));
  assign w_we_ecfg   = csr_wen && (csr_waddr == CSR_BIT'(CSR_ECFG));
  assign w_we_estat  = csr_wen && (csr_waddr == CSR_BIT'(CSR_ESTAT));
  assign w_we_era    = csr_wen && (csr_waddr == CSR_BIT'(CSR_ERA));
  assign w_we_eentry = csr_wen && (csr_waddr == CSR_BIT'(CSR_EENTRY));
  assign w_we_tid    = csr_wen && (csr_waddr == CSR_BIT'(CSR_TID));
  assign w_we_tcfg   = csr_wen && (csr_waddr == CSR_BIT'(CSR_TCFG));
  assign w_we_ticlr  = csr_wen && (csr_waddr == CSR_BIT'(CSR_TICLR));

  assign w_is    = {1'b0, r_ti, 1'b0, 8'(r_hwi), r_is_sw};
  assign w_estat = {1'b0, r_esub, r_ecode, 3'b000, w_is};

  cpu7_csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_tcfg_we   (w_we_tcfg),
    .i_tcfg_wdata(csr_wdata[TIMER_W-1:0]),
    .o_tcfg      (w_tcfg),
    .o_tval      (w_tval),
    .o_expire    (w_expire)
  );

  // Per-field priority: exception commit, then ERTN, then the CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd  <= '0;
      r_prmd  <= '0;
      r_era   <= '0;
      r_ecode <= '0;
      r_esub  <= '0;
    end else begin
      if (excp_valid)      r_crmd <= '0;
      else if (ertn_valid) r_crmd <= r_prmd;
      else if (w_we_crmd)  r_crmd <= mode_t'(csr_wdata[2:0]);

      if (excp_valid)      r_prmd <= r_crmd;
      else if (w_we_prmd)  r_prmd <= mode_t'(csr_wdata[2:0]);

      if (excp_valid)      r_era <= excp_pc;
      else if (w_we_era)   r_era <= csr_wdata;

      if (excp_valid) begin
        r_ecode <= excp_ecode;
        r_esub  <= excp_esubcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lie    <= '0;
      r_is_sw  <= '0;
      r_hwi    <= '0;
      r_ti     <= 1'b0;
      r_eentry <= '0;
      r_tid    <= '0;
      r_int    <= 1'b0;
    end else begin
      r_hwi <= hw_int;
      r_int <= r_crmd.ie & (|(w_is & r_lie));
      if (w_we_ecfg)   r_lie    <= csr_wdata[12:0] & ECFG_LIE_MASK;
      if (w_we_estat)  r_is_sw  <= csr_wdata[1:0];
      if (w_we_eentry) r_eentry <= csr_wdata[GRLEN-1:6];
      if (w_we_tid)    r_tid    <= csr_wdata;
      // An expiry in the same edge as a TICLR clear keeps the flag set.
      if (w_expire)                         r_ti <= 1'b1;
      else if (w_we_ticlr && csr_wdata[0])  r_ti <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SAVE; i++) begin
      if (reset)
        r_save[i] <= '0;
      else if (csr_wen && (csr_waddr == CSR_BIT'(CSR_SAVE0 + i)))
        r_save[i] <= csr_wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_BIT'(CSR_CRMD):   csr_rdata = GRLEN'(r_crmd);
      CSR_BIT'(CSR_PRMD):   csr_rdata = GRLEN'(r_prmd);
      CSR_BIT'(CSR_ECFG):   csr_rdata = GRLEN'(r_lie);
      CSR_BIT'(CSR_ESTAT):  csr_rdata = GRLEN'(w_estat);
      CSR_BIT'(CSR_ERA):    csr_rdata = r_era;
      CSR_BIT'(CSR_EENTRY): csr_rdata = {r_eentry, 6'b000000};
      CSR_BIT'(CSR_TID):    csr_rdata = r_tid;
      CSR_BIT'(CSR_TCFG):   csr_rdata = GRLEN'(w_tcfg);
      CSR_BIT'(CSR_TVAL):   csr_rdata = GRLEN'(w_tval);
      default: begin
        for (int i = 0; i < NUM_SAVE; i++)
          if (csr_raddr == CSR_BIT'(CSR_SAVE0 + i)) csr_rdata = r_save[i];
      end
    endcase
  end

  assign csr_eentry  = {r_eentry, 6'b000000};
  assign csr_era     = r_era;
  assign csr_plv     = r_crmd.plv;
  assign int_pending = r_int;

endmodule

// File: tb/tb_cpu7_csr_exc.sv
// Directed bench for cpu7_csr_exc: a vector table for register and exception
// behaviour, then hand sequences for the timer, interrupt latency and reset.
module tb_cpu7_csr_exc;

  localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04;
  localparam logic [13:0] A_ESTAT = 14'h05, A_ERA = 14'h06, A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE2 = 14'h32, A_TID = 14'h40, A_TCFG = 14'h41;
  localparam logic [13:0] A_TVAL = 14'h42, A_TICLR = 14'h44;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wen, excp_valid, ertn_valid;
  logic [5:0]  excp_ecode;
  logic [8:0]  excp_esubcode;
  logic [31:0] excp_pc;
  logic [7:0]  hw_int;
  logic [31:0] csr_eentry, csr_era;
  logic [1:0]  csr_plv;
  logic        int_pending;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wen;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic        excp;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc;
    logic        ertn;
    logic [13:0] raddr;
    logic [31:0] exp_rd;
    logic        chk_int;
    logic        exp_int;
  } vec_t;

  vec_t tbl[$];

  cpu7_csr_exc dut (
    .clk(clk), .reset(reset),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .excp_valid(excp_valid), .excp_ecode(excp_ecode),
    .excp_esubcode(excp_esubcode), .excp_pc(excp_pc),
    .ertn_valid(ertn_valid), .hw_int(hw_int),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .csr_plv(csr_plv),
    .int_pending(int_pending)
  );

  // clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wen, input logic [13:0] wa,
                              input logic [31:0] wd, input logic ex,
                              input logic [5:0] ec, input logic [8:0] es,
                              input logic [31:0] pc, input logic er,
                              input logic [13:0] ra, input logic [31:0] exp_rd,
                              input logic ci, input logic ei);
    vec_t v;
    v.wen = wen; v.waddr = wa; v.wdata = wd; v.excp = ex; v.ecode = ec;
    v.esub = es; v.pc = pc; v.ertn = er; v.raddr = ra; v.exp_rd = exp_rd;
    v.chk_int = ci; v.exp_int = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // driver: one clock edge, sampled 1ns later, strobes dropped afterwards
  task automatic tick();
    @(posedge clk);
    #1;
    csr_wen = 1'b0;
    excp_valid = 1'b0;
    ertn_valid = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_wen = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
  endtask

  task automatic rdm(input logic [13:0] a, input logic [31:0] mask,
                     input logic [31:0] exp_v, input string name);
    csr_raddr = a;
    #1;
    chk(name, csr_rdata & mask, exp_v);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_wen = 1'b0;
    excp_valid = 1'b0; excp_ecode = '0; excp_esubcode = '0; excp_pc = '0;
    ertn_valid = 1'b0; hw_int = '0;
    tick();
    tick();
    chk("rst_int", 32'(int_pending), 32'h0);
    chk("rst_plv", 32'(csr_plv), 32'h0);
    chk("rst_era", csr_era, 32'h0);
    rdm(A_CRMD, 32'hFFFFFFFF, 32'h0, "rst_crmd");
    reset = 1'b0;

    tbl.push_back(mk(1, A_CRMD,   32'h7,        0, 6'h00, 9'h000, 32'h0,        0, A_CRMD,   32'h7,        0, 0));
    tbl.push_back(mk(1, A_EENTRY, 32'h1C00013F, 0, 6'h00, 9'h000, 32'h0,        0, A_EENTRY, 32'h1C000100, 0, 0));
    tbl.push_back(mk(1, A_SAVE2,  32'hDEADBEEF, 0, 6'h00, 9'h000, 32'h0,        0, A_SAVE2,  32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 14'h3F,   32'hFFFFFFFF, 0, 6'h00, 9'h000, 32'h0,        0, 14'h3F,   32'h0,        0, 0));
    tbl.push_back(mk(1, 14'h34,   32'h12345678, 0, 6'h00, 9'h000, 32'h0,        0, 14'h34,   32'h0,        0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        1, 6'h0B, 9'h000, 32'h1C000040, 0, A_CRMD,   32'h0,        0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_PRMD,   32'h7,        0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ERA,    32'h1C000040, 0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ESTAT,  32'h000B0000, 0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        1, A_CRMD,   32'h7,        0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ERA,    32'h1C000040, 0, 0));
    tbl.push_back(mk(1, A_CRMD,   32'h3,        1, 6'h01, 9'h000, 32'h100,      0, A_CRMD,   32'h0,        0, 0));
    tbl.push_back(mk(1, A_PRMD,   32'h5,        0, 6'h00, 9'h000, 32'h0,        0, A_PRMD,   32'h5,        0, 0));
    tbl.push_back(mk(1, A_CRMD,   32'h3,        0, 6'h00, 9'h000, 32'h0,        1, A_CRMD,   32'h5,        0, 0));
    tbl.push_back(mk(1, A_ERA,    32'h200,      1, 6'h02, 9'h1FF, 32'h300,      0, A_ERA,    32'h300,      0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ESTAT,  32'h7FC20000, 0, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        1, A_CRMD,   32'h5,        0, 0));
    tbl.push_back(mk(1, A_ECFG,   32'hFFFFFFFF, 0, 6'h00, 9'h000, 32'h0,        0, A_ECFG,   32'h00000BFF, 0, 0));
    tbl.push_back(mk(1, A_ESTAT,  32'hFFFFFFFF, 0, 6'h00, 9'h000, 32'h0,        0, A_ESTAT,  32'h7FC20003, 1, 0));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ESTAT,  32'h7FC20003, 1, 1));
    tbl.push_back(mk(1, A_CRMD,   32'h1,        0, 6'h00, 9'h000, 32'h0,        0, A_CRMD,   32'h1,        1, 1));
    tbl.push_back(mk(0, A_CRMD,   32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_PRMD,   32'h5,        1, 0));
    tbl.push_back(mk(1, A_ESTAT,  32'h0,        0, 6'h00, 9'h000, 32'h0,        0, A_ESTAT,  32'h7FC20000, 1, 0));
    tbl.push_back(mk(1, A_TVAL,   32'h1234,     0, 6'h00, 9'h000, 32'h0,        0, A_TVAL,   32'h0,        0, 0));
    tbl.push_back(mk(1, A_TID,    32'hCAFEF00D, 0, 6'h00, 9'h000, 32'h0,        0, A_TID,    32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(1, A_TICLR,  32'h1,        0, 6'h00, 9'h000, 32'h0,        0, A_TICLR,  32'h0,        0, 0));
    tbl.push_back(mk(1, 14'h02,   32'hFFFFFFFF, 0, 6'h00, 9'h000, 32'h0,        0, 14'h02,   32'h0,        0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      csr_wen = v.wen; csr_waddr = v.waddr; csr_wdata = v.wdata;
      excp_valid = v.excp; excp_ecode = v.ecode; excp_esubcode = v.esub;
      excp_pc = v.pc; ertn_valid = v.ertn;
      exp_q.push_back(v.exp_rd);
      tick();
      csr_raddr = v.raddr;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, exp_q.pop_front());
      if (v.chk_int) chk($sformatf("vec%0d_int", i), 32'(int_pending), 32'(v.exp_int));
    end
    chk("out_plv", 32'(csr_plv), 32'h1);
    chk("out_era", csr_era, 32'h300);
    chk("out_eentry", csr_eentry, 32'h1C000100);

    // periodic timer with InitVal=8 feeding the timer interrupt
    wr(A_ECFG, 32'h800);
    wr(A_CRMD, 32'h4);
    wr(A_TCFG, 32'h23);
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h8, "tval_load");
    for (int k = 1; k <= 8; k++) begin
      tick();
      rdm(A_TVAL, 32'hFFFFFFFF, 32'(8 - k), $sformatf("tval_dec%0d", k));
      rdm(A_ESTAT, 32'h800, 32'h0, $sformatf("ti_early%0d", k));
    end
    tick();
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h8, "tval_reload");
    rdm(A_ESTAT, 32'h800, 32'h800, "ti_set");
    chk("int_lat0", 32'(int_pending), 32'h0);
    tick();
    chk("int_lat1", 32'(int_pending), 32'h1);
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h7, "tval_7");
    wr(A_CRMD, 32'h0);
    chk("int_ie_hold", 32'(int_pending), 32'h1);
    tick();
    chk("int_ie_off", 32'(int_pending), 32'h0);
    wr(A_TICLR, 32'h1);
    rdm(A_ESTAT, 32'h800, 32'h0, "ticlr");
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h4, "tval_4");
    repeat (4) tick();
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h0, "tval_0");
    wr(A_TICLR, 32'h1);
    rdm(A_ESTAT, 32'h800, 32'h800, "ticlr_vs_expire");
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h8, "tval_reload2");

    // one-shot timer
    wr(A_TCFG, 32'h21);
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h8, "os_load");
    wr(A_TICLR, 32'h1);
    rdm(A_ESTAT, 32'h800, 32'h0, "os_clr");
    repeat (7) tick();
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h0, "os_zero");
    rdm(A_TCFG, 32'hFFFFFFFF, 32'h21, "os_tcfg_en");
    tick();
    rdm(A_ESTAT, 32'h800, 32'h800, "os_ti");
    rdm(A_TCFG, 32'hFFFFFFFF, 32'h20, "os_en_clr");
    tick();
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h0, "os_hold");

    // InitVal=0 periodic: expiry every cycle beats TICLR
    wr(A_TICLR, 32'h1);
    rdm(A_ESTAT, 32'h800, 32'h0, "z_clr");
    wr(A_TCFG, 32'h3);
    tick();
    rdm(A_ESTAT, 32'h800, 32'h800, "z_ti");
    wr(A_TICLR, 32'h1);
    rdm(A_ESTAT, 32'h800, 32'h800, "z_ti_again");

    // hardware interrupt, then reset mid-count
    wr(A_ESTAT, 32'h0);
    wr(A_TICLR, 32'h1);
    wr(A_ECFG, 32'h4);
    wr(A_CRMD, 32'h4);
    wr(A_TCFG, 32'h23);
    hw_int = 8'h01;
    tick();
    rdm(A_ESTAT, 32'h3FC, 32'h4, "hwi_is");
    chk("hwi_int_lat0", 32'(int_pending), 32'h0);
    tick();
    chk("hwi_int", 32'(int_pending), 32'h1);
    hw_int = 8'h00;
    reset = 1'b1;
    tick();
    chk("mrst_int", 32'(int_pending), 32'h0);
    chk("mrst_era", csr_era, 32'h0);
    chk("mrst_eentry", csr_eentry, 32'h0);
    rdm(A_CRMD, 32'hFFFFFFFF, 32'h0, "mrst_crmd");
    rdm(A_TCFG, 32'hFFFFFFFF, 32'h0, "mrst_tcfg");
    rdm(A_SAVE2, 32'hFFFFFFFF, 32'h0, "mrst_save2");
    reset = 1'b0;
    repeat (3) tick();
    rdm(A_TVAL, 32'hFFFFFFFF, 32'h0, "timer_stopped");
    rdm(A_ESTAT, 32'hFFFFFFFF, 32'h0, "mrst_estat");
    chk("mrst_int_after", 32'(int_pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
